// File: rtl/bnn_window_ctrl.sv
// rtl/bnn_window_ctrl.sv - sequencer for the shift-register window buffer feeding the BNN XNOR/popcount stage
//
// Purpose:
//   Accepts a valid/ready sample stream, decides when the external window
//   buffer shifts, tracks fill level / stride / frame length, and presents
//   each complete window downstream with a valid/ready handshake.
//
// Ports:
//   clk, rst          - clock (rising edge), synchronous active-high reset
//   start             - one-cycle frame start pulse, honoured only in IDLE
//   in_valid/in_data  - upstream sample stream
//   in_ready          - controller accepts a sample this cycle
//   buf_shift/buf_din - shift enable and data into the external window buffer
//   buf_window        - concatenated window read back from the buffer
//   win_valid/win_data/win_ready - window handoff to the consumer
//   busy              - high in every state except IDLE
//   frame_done        - one-cycle pulse at frame end
//   win_count         - windows handed off in the current or last frame
//
// Optional feature:
//   BNN_WINDOW_CTRL_FLUSH_EN - when defined, frame end passes through a FLUSH
//   state that shifts LENGTH zeros into the buffer before DONE.

module bnn_window_ctrl #(
  parameter int WIDTH     = 5,
  parameter int LENGTH    = 5,
  parameter int STRIDE    = 1,
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      in_ready,
  output logic                      buf_shift,
  output logic [WIDTH-1:0]          buf_din,
  input  logic [WIDTH*LENGTH-1:0]   buf_window,
  output logic                      win_valid,
  output logic [WIDTH*LENGTH-1:0]   win_data,
  input  logic                      win_ready,
  output logic                      busy,
  output logic                      frame_done,
  output logic [CNT_W-1:0]          win_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] LEN_C   = CNT_W'(LENGTH);
  localparam logic [CNT_W-1:0] STR_C   = CNT_W'(STRIDE);
  localparam logic [CNT_W-1:0] FRM_C   = CNT_W'(FRAME_LEN);

`ifdef BNN_WINDOW_CTRL_FLUSH_EN
  typedef enum logic [2:0] {IDLE, FILL, STREAM, HOLD, FLUSH, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, FILL, STREAM, HOLD, DONE} state_t;
`endif

  state_t state, next_state, end_state;

  logic [CNT_W-1:0] fill_cnt;
  logic [CNT_W-1:0] sample_cnt;
  logic [CNT_W-1:0] stride_cnt;
  logic             accept;
  logic             win_hit;

`ifdef BNN_WINDOW_CTRL_FLUSH_EN
  logic [CNT_W-1:0] flush_cnt;
`endif

  // Next-state and output decode
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    buf_shift  = 1'b0;
    buf_din    = '0;
    win_valid  = 1'b0;
    win_data   = '0;
    busy       = 1'b1;
    frame_done = 1'b0;
    accept     = 1'b0;
    win_hit    = 1'b0;
`ifdef BNN_WINDOW_CTRL_FLUSH_EN
    end_state  = FLUSH;
`else
    end_state  = DONE;
`endif

    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) next_state = FILL;
      end

      FILL, STREAM: begin
        in_ready = 1'b1;
        accept   = in_valid;
        // The first window waits for a full buffer; later ones for STRIDE new samples.
        win_hit  = (state == FILL) ? (fill_cnt == LEN_C - CNT_ONE)
                                   : (stride_cnt == STR_C - CNT_ONE);
        if (accept) begin
          buf_shift = 1'b1;
          buf_din   = in_data;
          if (win_hit)
            next_state = HOLD;
          else if (sample_cnt == FRM_C - CNT_ONE)
            next_state = end_state;  // tail samples that never complete a window
        end
      end

      HOLD: begin
        // Buffer is frozen here, so the pass-through window stays stable.
        win_valid = 1'b1;
        win_data  = buf_window;
        if (win_ready)
          next_state = (sample_cnt == FRM_C) ? end_state : STREAM;
      end

`ifdef BNN_WINDOW_CTRL_FLUSH_EN
      FLUSH: begin
        buf_shift = 1'b1;  // buf_din stays 0: shifts zeros through every stage
        if (flush_cnt == LEN_C - CNT_ONE) next_state = DONE;
      end
`endif

      DONE: begin
        frame_done = 1'b1;
        next_state = IDLE;
      end

      default: next_state = IDLE;
    endcase
  end

  // State register and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      fill_cnt   <= '0;
      sample_cnt <= '0;
      stride_cnt <= '0;
      win_count  <= '0;
`ifdef BNN_WINDOW_CTRL_FLUSH_EN
      flush_cnt  <= '0;
`endif
    end else begin
      state <= next_state;

      if (state == IDLE && start) begin
        fill_cnt   <= '0;
        sample_cnt <= '0;
        stride_cnt <= '0;
        win_count  <= '0;
      end

      if (accept) begin
        sample_cnt <= sample_cnt + CNT_ONE;
        stride_cnt <= stride_cnt + CNT_ONE;
        if (fill_cnt != LEN_C) fill_cnt <= fill_cnt + CNT_ONE;
      end

      // Stride is measured from the window just presented.
      if (state != HOLD && next_state == HOLD) stride_cnt <= '0;

      if (state == HOLD && win_ready) win_count <= win_count + CNT_ONE;

`ifdef BNN_WINDOW_CTRL_FLUSH_EN
      if (state == FLUSH) flush_cnt <= flush_cnt + CNT_ONE;
      else                flush_cnt <= '0;
`endif
    end
  end

endmodule

// File: doc/bnn_window_ctrl.md
Name: bnn_window_ctrl

Overview:
- Sequencer for the shift-register window buffer (WIDTH bits x LENGTH stages, concatenated window output) that feeds the binarized XNOR/popcount stage.
- Accepts a valid/ready sample stream and decides when the external buffer shifts.
- Tracks fill level, stride and frame length, and presents each complete window downstream with a valid/ready handshake.
- Stale samples from a previous frame never reach the consumer.

Parameters:
- WIDTH, 5, bits per sample.
- LENGTH, 5, buffer stages (window depth).
- STRIDE, 1, new samples between successive windows after the first; must be >= 1.
- FRAME_LEN, 8, samples per frame; must be >= LENGTH.
- CNT_W, 16, width of internal counters and win_count.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE.
- in_valid  in  1  upstream sample valid.
- in_data  in  WIDTH  upstream sample.
- in_ready  out  1  controller accepts a sample this cycle.
- buf_shift  out  1  shift enable to the window buffer.
- buf_din  out  WIDTH  data into the window buffer.
- buf_window  in  WIDTH*LENGTH  concatenated window from the buffer.
- win_valid  out  1  window available to the consumer.
- win_data  out  WIDTH*LENGTH  window to the consumer.
- win_ready  in  1  consumer accepts the window.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse at frame end.
- win_count  out  CNT_W  windows handed off in the current or last frame.

Behaviour:
- Clock/reset: one clock, clk. Reset is rst, synchronous and active-high.
- Reset values: all outputs 0 and state IDLE. Reset mid-operation aborts the frame with no frame_done pulse.
- States: IDLE, FILL, STREAM, HOLD, FLUSH (macro only), DONE.
- IDLE:
  - in_ready=0, busy=0.
  - start=1 moves to FILL and clears fill_cnt, sample_cnt, stride_cnt and win_count.
  - start outside IDLE is ignored.
- FILL and STREAM:
  - in_ready=1.
  - An accept is in_valid&in_ready. On an accept, buf_shift=1 and buf_din=in_data combinationally in the same cycle, so the buffer updates on that edge.
  - With no accept, buf_shift=0 and buf_din=0.
  - Each accept: sample_cnt+1, fill_cnt+1 (saturates at LENGTH), stride_cnt+1.
- FILL to HOLD: on the accept that makes fill_cnt==LENGTH.
- STREAM to HOLD: on the accept where stride_cnt+1==STRIDE.
- Entering HOLD clears stride_cnt.
- Tail: if an accept makes sample_cnt==FRAME_LEN without triggering a window, the next state is DONE (FLUSH with the macro).
- HOLD:
  - win_valid=1, in_ready=0, buf_shift=0.
  - win_data=buf_window, passed through unmodified. It is held stable because the buffer cannot shift.
  - Latency: win_valid rises the cycle after the completing accept.
  - On win_ready=1: win_count+1. Next state is DONE (FLUSH with the macro) if sample_cnt==FRAME_LEN, else STREAM.
  - win_ready outside HOLD is ignored.
- DONE: frame_done=1 for one cycle, then IDLE. win_count holds until the next start.
- Outside HOLD: win_valid=0, win_data=0.
- Windows per frame: 1+floor((FRAME_LEN-LENGTH)/STRIDE).
- Counters compare by equality and never wrap within a legal frame.

Optional Feature:
- Macro: BNN_WINDOW_CTRL_FLUSH_EN.
- Defined:
  - At frame end the controller enters FLUSH instead of DONE.
  - FLUSH drives buf_shift=1 with buf_din=0 for exactly LENGTH cycles, in_ready=0, busy=1, then goes to DONE.
  - The buffer is zeroed before the next frame.
- Undefined: no FLUSH state; frame end goes straight to DONE. fill_cnt gating alone prevents stale data from being emitted.

Test Plan:
- Defaults (W=5, L=5, S=1, F=8); start, then samples 10,12,3,7,1,4,9,2 with win_ready=1 -> 4 windows; first win_valid 1 cycle after the 5th accept; frame_done after the 4th handoff; win_count=4.
- S=2, F=9; 9 samples -> windows after accepts 5, 7 and 9; win_count=3; frame_done once.
- win_ready held 0 for 3 cycles in HOLD -> in_ready=0, buf_shift=0, win_data constant; handoff on the 4th cycle; win_count+1 exactly once.
- rst=1 after 3 accepts -> next cycle IDLE with all outputs 0; new start then needs 5 fresh accepts before win_valid.
- start pulsed while busy -> no effect on counters or state; in_valid=0 in FILL -> buf_shift=0.
- With BNN_WINDOW_CTRL_FLUSH_EN, defaults -> exactly 5 buf_shift cycles with buf_din=0 after the last handoff, then frame_done.
